// File: rtl/hcsr04_emulador_if.sv
// -----------------------------------------------------------------------------
// hcsr04_emulador_if
// Sensor-side bundle between a sonar controller (master) and the HC-SR04
// emulator (slave).
//
// Signals:
//   trigger      master -> slave  trigger pulse, asynchronous to the sensor clock
//   distancia_cm master -> slave  simulated distance in cm, sampled at echo rise
//   echo         slave -> master  echo pulse, width proportional to distance
//   ocupado      slave -> master  sensor busy (any state other than idle)
//   fim_eco      slave -> master  one-cycle pulse on the cycle after echo falls
//   erro_trigger slave -> master  one-cycle pulse when a trigger is too short
//
// Handshake: this is a pulse protocol with no valid/ready pair. A request is
// a trigger pulse at least the minimum width long. It is accepted only while
// ocupado is low. The response is exactly one of: an echo pulse followed by a
// fim_eco strobe, or an erro_trigger strobe. Triggers seen while ocupado is
// high are dropped, not queued.
// -----------------------------------------------------------------------------
interface hcsr04_emulador_if;
    logic       trigger;
    logic [8:0] distancia_cm;
    logic       echo;
    logic       ocupado;
    logic       fim_eco;
    logic       erro_trigger;

    modport master (
        output trigger,
        output distancia_cm,
        input  echo,
        input  ocupado,
        input  fim_eco,
        input  erro_trigger
    );

    modport slave (
        input  trigger,
        input  distancia_cm,
        output echo,
        output ocupado,
        output fim_eco,
        output erro_trigger
    );
endinterface

// File: rtl/hcsr04_emulador.sv
// -----------------------------------------------------------------------------
// hcsr04_emulador
// Synthesizable HC-SR04 ultrasonic sensor model. The module watches trigger
// and checks that its width is at least the minimum. It then waits the burst
// delay and drives echo high for distancia_cm * CICLOS_POR_CM clock cycles.
// When the distance is out of range, it uses the timeout width instead.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-low reset
//   bus         hcsr04_emulador_if.slave (trigger, distancia_cm, echo,
//               ocupado, fim_eco, erro_trigger)
//   estado_dbg  current FSM state encoding (0 OCIOSO, 1 MEDE_TRIG, 2 ATRASO,
//               3 ECO, 4 ESPERA)
//
// Optional feature: define HCSR04_RUIDO_EN to add 0..15 cycles of pseudo-
// random jitter to every echo width. The jitter comes from an 8-bit LFSR.
// When the macro is undefined there is no LFSR and widths are exact.
// -----------------------------------------------------------------------------
module hcsr04_emulador #(
    parameter int CLK_POR_US    = 50,
    parameter int TRIG_MIN_US   = 10,
    parameter int ATRASO_US     = 400,
    parameter int CICLOS_POR_CM = 2941,
    parameter int MAX_CM        = 400,
    parameter int TIMEOUT_US    = 38000,
    parameter int ESPERA_US     = 100
) (
    input  logic                    clock,
    input  logic                    reset,
    hcsr04_emulador_if.slave        bus,
    output logic [2:0]              estado_dbg
);

    localparam logic [20:0] TRIG_MIN_CICLOS = 21'(TRIG_MIN_US * CLK_POR_US);
    localparam logic [20:0] ATRASO_CICLOS   = 21'(ATRASO_US * CLK_POR_US);
    localparam logic [20:0] ESPERA_CICLOS   = 21'(ESPERA_US * CLK_POR_US);
    localparam logic [20:0] TIMEOUT_CICLOS  = 21'(TIMEOUT_US * CLK_POR_US);
    localparam logic [20:0] CICLOS_CM       = 21'(CICLOS_POR_CM);
    localparam logic [8:0]  MAX_DIST        = 9'(MAX_CM);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        MEDE_TRIG = 3'd1,
        ATRASO    = 3'd2,
        ECO       = 3'd3,
        ESPERA    = 3'd4
    } estado_t;

    estado_t     estado, estado_prox;
    logic [20:0] cnt, cnt_prox;
    logic [20:0] largura, largura_prox;
    logic [20:0] largura_base;
    logic [20:0] largura_nova;

    logic sinc_1;
    logic trig_s;
    logic trig_q;
    logic subida;
    logic descida;

    // Two-flop synchronizer plus a registered copy for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_1 <= 1'b0;
            trig_s <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            sinc_1 <= bus.trigger;
            trig_s <= sinc_1;
            trig_q <= trig_s;
        end
    end

    assign subida  = trig_s & ~trig_q;
    assign descida = ~trig_s & trig_q;

    // Echo width for the current distance. The 21-bit product holds
    // MAX_CM * CICLOS_POR_CM without truncation.
    always_comb begin
        if (bus.distancia_cm == 9'd0 || bus.distancia_cm > MAX_DIST) begin
            largura_base = TIMEOUT_CICLOS;
        end else begin
            largura_base = 21'(bus.distancia_cm) * CICLOS_CM;
        end
    end

`ifdef HCSR04_RUIDO_EN
    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form, advancing every clock
    logic [7:0] lfsr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign largura_nova = largura_base + 21'(lfsr[3:0]);
`else
    assign largura_nova = largura_base;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= OCIOSO;
            cnt     <= '0;
            largura <= '0;
        end else begin
            estado  <= estado_prox;
            cnt     <= cnt_prox;
            largura <= largura_prox;
        end
    end

    // Next-state and counter logic
    always_comb begin
        estado_prox  = estado;
        cnt_prox     = cnt;
        largura_prox = largura;
        case (estado)
            OCIOSO: begin
                // A trigger already high on return here shows no rise and is ignored
                if (subida) begin
                    estado_prox = MEDE_TRIG;
                    cnt_prox    = 21'd1;
                end
            end
            MEDE_TRIG: begin
                if (descida) begin
                    estado_prox = (cnt >= TRIG_MIN_CICLOS) ? ATRASO : OCIOSO;
                    cnt_prox    = '0;
                end else if (trig_s && cnt < TRIG_MIN_CICLOS) begin
                    // Saturating: a stuck-high trigger parks here without overflow
                    cnt_prox = cnt + 21'd1;
                end
            end
            ATRASO: begin
                if (cnt == ATRASO_CICLOS - 21'd1) begin
                    estado_prox  = ECO;
                    cnt_prox     = 21'd1;
                    largura_prox = largura_nova;
                end else begin
                    cnt_prox = cnt + 21'd1;
                end
            end
            ECO: begin
                // cnt starts at 1 on entry, so ECO lasts exactly largura cycles
                if (cnt >= largura) begin
                    estado_prox = ESPERA;
                    cnt_prox    = '0;
                end else begin
                    cnt_prox = cnt + 21'd1;
                end
            end
            ESPERA: begin
                if (cnt == ESPERA_CICLOS - 21'd1) begin
                    estado_prox = OCIOSO;
                    cnt_prox    = '0;
                end else begin
                    cnt_prox = cnt + 21'd1;
                end
            end
            default: begin
                estado_prox = OCIOSO;
                cnt_prox    = '0;
            end
        endcase
    end

    // Outputs decode from registered state, so reset clears them at once
    always_comb begin
        bus.echo         = (estado == ECO);
        bus.ocupado      = (estado != OCIOSO);
        // cnt is 0 only on the first ESPERA cycle, which is the cycle after echo falls
        bus.fim_eco      = (estado == ESPERA) && (cnt == '0);
        bus.erro_trigger = (estado == MEDE_TRIG) && descida && (cnt < TRIG_MIN_CICLOS);
        estado_dbg       = estado;
    end

endmodule

// File: tb/tb_hcsr04_emulador.sv
// -----------------------------------------------------------------------------
// tb_hcsr04_emulador
// Directed bench for hcsr04_emulador. The timing parameters are scaled down so
// that every scenario runs in a few thousand cycles.
//   2 cycles/us, trigger min 3 us = 6 cycles, delay 5 us = 10 cycles,
//   3 cycles/cm, max 400 cm, timeout 700 us = 1400 cycles, hold-off 4 us = 8 cycles
// Stimulus pushes the expected response onto exp_q: 0 for a rejected trigger,
// otherwise the echo width. The monitor pops one entry per DUT response.
// -----------------------------------------------------------------------------
module tb_hcsr04_emulador;

    localparam int CLK_POR_US    = 2;
    localparam int TRIG_MIN_US   = 3;
    localparam int ATRASO_US     = 5;
    localparam int CICLOS_POR_CM = 3;
    localparam int MAX_CM        = 400;
    localparam int TIMEOUT_US    = 700;
    localparam int ESPERA_US     = 4;

    // Hand-computed cycle counts for the parameters above
    localparam int ATRASO_CIC  = 10;
    localparam int TIMEOUT_CIC = 1400;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] estado_dbg;

    hcsr04_emulador_if bus ();

    hcsr04_emulador #(
        .CLK_POR_US   (CLK_POR_US),
        .TRIG_MIN_US  (TRIG_MIN_US),
        .ATRASO_US    (ATRASO_US),
        .CICLOS_POR_CM(CICLOS_POR_CM),
        .MAX_CM       (MAX_CM),
        .TIMEOUT_US   (TIMEOUT_US),
        .ESPERA_US    (ESPERA_US)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .estado_dbg(estado_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int unsigned ciclo = 0;
    always @(posedge clock) ciclo <= ciclo + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [20:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned ciclo_queda = 0;

    task automatic check(input string nome, input longint atual,
                         input longint lo, input longint hi);
        checks++;
        if (atual < lo || atual > hi) begin
            failures++;
            if (lo == hi)
                $display("FAIL %s: got %0d, expected %0d", nome, atual, lo);
            else
                $display("FAIL %s: got %0d, expected %0d..%0d", nome, atual, lo, hi);
        end
    endtask

    // ---------------- monitor ----------------
    logic        em_eco = 1'b0;
    int unsigned largura_med = 0;
    logic [20:0] esperado;

    always @(negedge clock) begin
        if (!reset) begin
            em_eco      = 1'b0;
            largura_med = 0;
        end else begin
            if (bus.erro_trigger) begin
                if (exp_q.size() == 0) begin
                    check("erro_trigger_unexpected", 1, 0, 0);
                end else begin
                    esperado = exp_q.pop_front();
                    check("event_kind_reject", 0, esperado, esperado);
                end
            end
            if (bus.echo) begin
                if (!em_eco) begin
                    em_eco      = 1'b1;
                    largura_med = 0;
                    check("echo_latency", ciclo - ciclo_queda, ATRASO_CIC + 2, ATRASO_CIC + 3);
                end
                largura_med++;
            end else if (em_eco) begin
                em_eco = 1'b0;
                check("fim_eco_after_fall", bus.fim_eco, 1, 1);
                if (exp_q.size() == 0) begin
                    check("echo_unexpected", largura_med, 0, 0);
                end else begin
                    esperado = exp_q.pop_front();
                    check("echo_width", largura_med, esperado, esperado);
                end
            end else if (bus.fim_eco) begin
                check("fim_eco_spurious", 1, 0, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic disparar(input int n);
        @(negedge clock);
        bus.trigger = 1'b1;
        repeat (n) @(negedge clock);
        bus.trigger = 1'b0;
        ciclo_queda = ciclo;
    endtask

    task automatic espera_ocioso(input int limite);
        int k = 0;
        repeat (4) @(negedge clock);
        while (bus.ocupado && k < limite) begin
            @(negedge clock);
            k++;
        end
        check("return_to_idle", bus.ocupado, 0, 0);
    endtask

    task automatic espera_eco(input int limite);
        int k = 0;
        while (!bus.echo && k < limite) begin
            @(negedge clock);
            k++;
        end
        check("echo_rise_seen", bus.echo, 1, 1);
    endtask

    task automatic espera_fim_eco(input int limite);
        int k = 0;
        while (!bus.fim_eco && k < limite) begin
            @(negedge clock);
            k++;
        end
        check("fim_eco_seen", bus.fim_eco, 1, 1);
    endtask

    // Out-of-range and edge distances with hand-computed widths
    int unsigned dist_tab[5] = '{0, 450, 400, 401, 1};
    int unsigned larg_tab[5] = '{TIMEOUT_CIC, TIMEOUT_CIC, 1200, TIMEOUT_CIC, 3};

    // ---------------- stimulus ----------------
    initial begin
        bus.trigger      = 1'b0;
        bus.distancia_cm = 9'd0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);

        check("reset_echo",         bus.echo,         0, 0);
        check("reset_ocupado",      bus.ocupado,      0, 0);
        check("reset_fim_eco",      bus.fim_eco,      0, 0);
        check("reset_erro_trigger", bus.erro_trigger, 0, 0);
        check("reset_state",        estado_dbg,       0, 0);

        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Short triggers: 3 cycles, then one below the minimum
        exp_q.push_back(21'd0);
        disparar(3);
        espera_ocioso(50);
        check("echo_after_short", bus.echo, 0, 0);
        exp_q.push_back(21'd0);
        disparar(5);
        espera_ocioso(50);

        // Trigger exactly at the minimum width, 100 cm
        bus.distancia_cm = 9'd100;
        exp_q.push_back(21'd300);
        disparar(6);
        espera_ocioso(2000);

        // Trigger held high: stays in MEDE_TRIG, then accepted on release
        exp_q.push_back(21'd300);
        @(negedge clock);
        bus.trigger = 1'b1;
        repeat (40) @(negedge clock);
        check("held_trigger_state", estado_dbg, 1, 1);
        check("held_trigger_echo",  bus.echo,   0, 0);
        bus.trigger = 1'b0;
        ciclo_queda = ciclo;
        espera_ocioso(2000);

        // 75 cm with a valid-width trigger during ESPERA, which is ignored
        bus.distancia_cm = 9'd75;
        exp_q.push_back(21'd225);
        disparar(6);
        espera_fim_eco(2000);
        bus.trigger = 1'b1;
        repeat (6) @(negedge clock);
        bus.trigger = 1'b0;
        repeat (20) @(negedge clock);
        check("espera_trigger_ignored", bus.ocupado, 0, 0);

        // 54 cm, then a trigger still high on return to OCIOSO
        bus.distancia_cm = 9'd54;
        exp_q.push_back(21'd162);
        disparar(6);
        espera_fim_eco(2000);
        bus.trigger = 1'b1;
        repeat (20) @(negedge clock);
        bus.trigger = 1'b0;
        repeat (10) @(negedge clock);
        check("held_across_idle_ignored", bus.ocupado, 0, 0);

        // Invalid and boundary distances
        for (int i = 0; i < 5; i++) begin
            bus.distancia_cm = 9'(dist_tab[i]);
            exp_q.push_back(21'(larg_tab[i]));
            disparar(6);
            espera_ocioso(3000);
        end

        // Distance sampled at echo rise: a change during ATRASO takes effect
        bus.distancia_cm = 9'd50;
        exp_q.push_back(21'd30);
        disparar(6);
        repeat (5) @(negedge clock);
        bus.distancia_cm = 9'd10;
        espera_ocioso(2000);

        // A change during ECO has no effect
        bus.distancia_cm = 9'd20;
        exp_q.push_back(21'd60);
        disparar(6);
        espera_eco(100);
        bus.distancia_cm = 9'd200;
        espera_ocioso(2000);

        // Reset mid-echo drops echo asynchronously
        bus.distancia_cm = 9'd300;
        disparar(6);
        espera_eco(100);
        repeat (100) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midreset_echo",    bus.echo,    0, 0);
        check("midreset_ocupado", bus.ocupado, 0, 0);
        check("midreset_state",   estado_dbg,  0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("after_reset_state", estado_dbg, 0, 0);

        // Normal measurement after reset
        bus.distancia_cm = 9'd100;
        exp_q.push_back(21'd300);
        disparar(6);
        espera_ocioso(2000);

        repeat (5) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
